div_iter: RTL and testbench

- Iterative radix-2 restoring divider; the responder end of the ALU divide handshake (div_valid / div_o_valid / div_o_ready / div_flush).
- Port-compatible drop-in for the EX-stage divider slot; the ALU performs word (DIVW/REMW) sign/zero extension and result truncation.
- Implements RISC-V M-extension DIV/DIVU/REM/REMU semantics, including divide-by-zero and signed overflow.

---
 rtl/div_iter_pkg.sv | 13 +
 rtl/add_with_Cout.sv | 14 +
 rtl/div_iter.sv | 135 +++++++++++++
 tb/tb_div_iter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative restoring divider: state encoding and default width.
package div_iter_pkg;

  localparam int XLEN_DEF = 64;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/add_with_Cout.sv
// Plain ripple-free adder with carry in and carry out; used as the divider's trial subtractor.
module add_with_Cout #(
  parameter int WIDTH = 65
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider with RISC-V DIV/DIVU/REM/REMU semantics.
// One quotient bit per cycle, sign fix-up in a separate cycle, result held until accepted.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            div_flush,
  input  logic            div_valid,
  input  logic            div_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            div_o_valid,
  input  logic            div_o_ready
);

  localparam int CW = $clog2(XLEN);

  div_state_e      state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] dvd_q;
  logic [XLEN-1:0] dsr_q;
  logic [XLEN-1:0] rem_q;
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic [XLEN-1:0] quotient_q;
  logic [XLEN-1:0] remainder_q;
  logic            valid_q;

  logic            dvd_neg;
  logic            dsr_neg;
  logic [XLEN-1:0] abs_dvd;
  logic [XLEN-1:0] abs_dsr;
  logic            is_ovf;

  logic [XLEN:0]   trial_a;
  logic [XLEN:0]   trial_b;
  logic [XLEN:0]   trial_sum;
  logic            trial_cout;
  logic            trial_ok;

  assign dvd_neg = div_signed & dividend[XLEN-1];
  assign dsr_neg = div_signed & divisor[XLEN-1];
  assign abs_dvd = dvd_neg ? -dividend : dividend;
  assign abs_dsr = dsr_neg ? -divisor : divisor;
  assign is_ovf  = div_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);

  // Dividend register doubles as the quotient shift register: its MSB feeds the
  // partial remainder while the new quotient bit enters at the LSB.
  assign trial_a = {rem_q, dvd_q[XLEN-1]};
  assign trial_b = ~{1'b0, dsr_q};

  add_with_Cout #(.WIDTH(XLEN+1)) u_trial_sub (
    .a_i    (trial_a),
    .b_i    (trial_b),
    .cin_i  (1'b1),
    .sum_o  (trial_sum),
    .cout_o (trial_cout)
  );

  // No borrow out means the difference is non-negative; its sign bit is then clear too.
  assign trial_ok = trial_cout & ~trial_sum[XLEN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      valid_q     <= 1'b0;
    end else if (div_flush) begin
      state_q <= DIV_IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (div_valid) begin
            if (divisor == '0) begin
              quotient_q  <= '1;
              remainder_q <= dividend;
              valid_q     <= 1'b1;
              state_q     <= DIV_DONE;
            end else if (is_ovf) begin
              quotient_q  <= dividend;
              remainder_q <= '0;
              valid_q     <= 1'b1;
              state_q     <= DIV_DONE;
            end else begin
              dvd_q     <= abs_dvd;
              dsr_q     <= abs_dsr;
              rem_q     <= '0;
              neg_quo_q <= dvd_neg ^ dsr_neg;
              neg_rem_q <= dvd_neg;
              cnt_q     <= CW'(XLEN-1);
              state_q   <= DIV_CALC;
            end
          end
        end
        DIV_CALC: begin
          dvd_q <= {dvd_q[XLEN-2:0], trial_ok};
          rem_q <= trial_ok ? trial_sum[XLEN-1:0] : trial_a[XLEN-1:0];
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= DIV_FIX;
        end
        DIV_FIX: begin
          quotient_q  <= neg_quo_q ? -dvd_q : dvd_q;
          remainder_q <= neg_rem_q ? -rem_q : rem_q;
          valid_q     <= 1'b1;
          state_q     <= DIV_DONE;
        end
        DIV_DONE: begin
          if (div_o_ready) begin
            valid_q <= 1'b0;
            state_q <= DIV_IDLE;
          end
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_o_valid = valid_q;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed cases plus randomized operations against an arithmetic model.
module tb_div_iter;

  localparam int XLEN = 64;
  localparam logic [63:0] INT_MIN = 64'h8000_0000_0000_0000;

  logic            clk;
  logic            rst_n;
  logic            div_flush;
  logic            div_valid;
  logic            div_signed;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;
  logic            div_o_valid;
  logic            div_o_ready;

  int checks   = 0;
  int failures = 0;

  div_iter #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .div_flush   (div_flush),
    .div_valid   (div_valid),
    .div_signed  (div_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_o_valid (div_o_valid),
    .div_o_ready (div_o_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // RISC-V M-extension reference: SV signed division truncates toward zero like DIV/REM.
  task automatic ref_div(input bit sgn, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] q, output logic [63:0] r, output int lat);
    longint sa, sb;
    sa = a;
    sb = b;
    if (b == 64'd0) begin
      q = '1; r = a; lat = 1;
    end else if (sgn && a == INT_MIN && b == '1) begin
      q = a; r = '0; lat = 1;
    end else if (sgn) begin
      q = sa / sb; r = sa % sb; lat = XLEN + 2;
    end else begin
      q = a / b; r = a % b; lat = XLEN + 2;
    end
  endtask

  // Entered and left at 1 time unit after a rising edge, DUT idle.
  task automatic run_op(input bit sgn, input logic [63:0] a, input logic [63:0] b,
                        input int hold, input bit noisy);
    logic [63:0] q, r;
    int lat, cyc;
    ref_div(sgn, a, b, q, r, lat);
    div_signed  = sgn;
    dividend    = a;
    divisor     = b;
    div_valid   = 1'b1;
    div_o_ready = 1'b0;
    @(posedge clk); #1;
    div_valid = noisy;
    cyc = 1;
    while (!div_o_valid && cyc < 200) begin
      if (noisy) begin
        dividend   = {$urandom, $urandom};
        divisor    = {$urandom, $urandom};
        div_signed = $urandom_range(0, 1);
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", 64'(cyc), 64'(lat));
    chk("quotient", quotient, q);
    chk("remainder", remainder, r);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(div_o_valid), 64'd1);
      chk("hold_quotient", quotient, q);
      chk("hold_remainder", remainder, r);
    end
    div_o_ready = 1'b1;
    @(posedge clk); #1;
    div_o_ready = 1'b0;
    div_valid   = 1'b0;
    chk("release_valid", 64'(div_o_valid), 64'd0);
  endtask

  initial begin
    int cyc;
    bit seen;
    logic [63:0] a, b;

    rst_n       = 1'b0;
    div_flush   = 1'b0;
    div_valid   = 1'b0;
    div_signed  = 1'b0;
    dividend    = '0;
    divisor     = '0;
    div_o_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 64'(div_o_valid), 64'd0);
    chk("reset_quotient", quotient, 64'd0);
    chk("reset_remainder", remainder, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(1'b0, 64'd100, 64'd7, 0, 1'b0);
    run_op(1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 2, 1'b0);
    run_op(1'b0, 64'h1234, 64'd0, 1, 1'b1);
    run_op(1'b1, INT_MIN, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1);
    run_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 5, 1'b0);
    run_op(1'b0, INT_MIN, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);
    run_op(1'b1, INT_MIN, 64'd3, 1, 1'b1);

    // Flush in the middle of a calculation: result must never appear.
    div_signed = 1'b0;
    dividend   = 64'd12345;
    divisor    = 64'd67;
    div_valid  = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0;
    cyc = 1;
    while (cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    div_flush = 1'b1;
    @(posedge clk); #1;
    div_flush = 1'b0;
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (div_o_valid) seen = 1'b1;
    end
    chk("flush_calc_no_valid", 64'(seen), 64'd0);
    run_op(1'b0, 64'd10, 64'd3, 0, 1'b0);

    // Flush together with a request in IDLE: a zero divisor would otherwise show valid at once.
    div_signed = 1'b0;
    dividend   = 64'd55;
    divisor    = 64'd0;
    div_valid  = 1'b1;
    div_flush  = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0;
    div_flush = 1'b0;
    chk("flush_beats_request", 64'(div_o_valid), 64'd0);
    @(posedge clk); #1;
    chk("flush_beats_request_2", 64'(div_o_valid), 64'd0);

    // Flush while holding a result, with the consumer not ready.
    div_signed = 1'b0;
    dividend   = 64'd50;
    divisor    = 64'd0;
    div_valid  = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0;
    chk("done_before_flush", 64'(div_o_valid), 64'd1);
    div_flush = 1'b1;
    @(posedge clk); #1;
    div_flush = 1'b0;
    chk("flush_done_valid", 64'(div_o_valid), 64'd0);
    run_op(1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 1, 1'b0);

    // Asynchronous reset mid-operation clears outputs without waiting for an edge.
    div_signed = 1'b0;
    dividend   = 64'd999;
    divisor    = 64'd10;
    div_valid  = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_quotient", quotient, 64'd0);
    chk("async_reset_remainder", remainder, 64'd0);
    chk("async_reset_valid", 64'(div_o_valid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(1'b0, 64'd1000, 64'd10, 0, 1'b0);

    for (int n = 0; n < 25; n++) begin
      case ($urandom_range(0, 4))
        0: begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; end
        1: begin a = {$urandom, $urandom}; b = 64'($urandom_range(1, 1000)); end
        2: begin a = {$urandom, $urandom}; b = 64'd0; end
        3: begin a = INT_MIN; b = '1; end
        default: begin a = 64'($urandom_range(0, 500)); b = {$urandom, $urandom}; end
      endcase
      if ($urandom_range(0, 3) == 0) b = -b;
      run_op(1'($urandom_range(0, 1)), a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
